// File: rtl/sram_like_responder_pkg.sv
// Shared constants for the SRAM-like bus responder.
// Optional feature macro: SRAM_RANDOM_DELAY_EN (LFSR-driven stalls and latency jitter).
package sram_like_responder_pkg;

   // Transfer size encodings carried on the size field
   localparam logic [1:0] SRAM_SIZE_B = 2'd0;
   localparam logic [1:0] SRAM_SIZE_H = 2'd1;
   localparam logic [1:0] SRAM_SIZE_W = 2'd2;

   // Width of the data field held in each response queue entry
   localparam int ENTRY_DATA_W = 32;

`ifdef SRAM_RANDOM_DELAY_EN
   // 16-bit Galois LFSR, taps 16,14,13,11 (right-shifting form)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction
`endif

endpackage

// File: rtl/sram_like_responder_if.sv
// SRAM-like request/response bus (req / addr_ok / data_ok).
// Optional feature macro: SRAM_RANDOM_DELAY_EN (no effect on the interface).
interface sram_like_responder_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_resp_fifo.sv
// Circular response queue; every slot carries its own countdown timer.
// Optional feature macro: SRAM_RANDOM_DELAY_EN (only changes the loaded timer value).
module sram_resp_fifo
   import sram_like_responder_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int TIMER_W = 3
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    push,
   input  logic [ENTRY_DATA_W-1:0] push_data,
   input  logic [TIMER_W-1:0]      push_timer,
   input  logic                    pop,
   output logic                    empty,
   output logic                    head_expired,
   output logic [ENTRY_DATA_W-1:0] head_data,
   output logic                    full_next
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [DEPTH-1:0][ENTRY_DATA_W-1:0] slot_data;
   logic [DEPTH-1:0][TIMER_W-1:0]      slot_timer;

   // Pointers wrap by explicit compare so any depth 1..4 works
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [ENTRY_DATA_W-1:0] data_q, data_d;
      logic [TIMER_W-1:0]      timer_q, timer_d;
      logic                    load;

      assign load = push && (wr_ptr_q == PTR_W'(gi));

      // A push reloads the slot; otherwise its timer runs down to zero
      always_comb begin
         data_d  = data_q;
         timer_d = timer_q;
         if (load) begin
            data_d  = push_data;
            timer_d = push_timer;
         end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
         end
      end

      // Slot storage
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            data_q  <= '0;
            timer_q <= '0;
         end else begin
            data_q  <= data_d;
            timer_q <= timer_d;
         end
      end

      assign slot_data[gi]  = data_q;
      assign slot_timer[gi] = timer_q;
   end

   // Pointer and occupancy bookkeeping; push and pop move independently
   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      empty        = (count_q == '0);
      head_expired = (slot_timer[rd_ptr_q] == '0);
      head_data    = slot_data[rd_ptr_q];
      full_next    = (count_d == CNT_W'(DEPTH));
   end

   // Pointer and count registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/sram_like_responder.sv
// Slave end of the SRAM-like bus: word-addressed backing memory with
// in-order responses after a fixed latency.
// Optional feature macro: SRAM_RANDOM_DELAY_EN (LFSR stalls addr_ok and adds 0-3 cycles).
module sram_like_responder
   import sram_like_responder_pkg::*;
#(
   parameter int ADDR_W          = 10,
   parameter int MAX_OUTSTANDING = 2,
   parameter int DATA_LAT        = 2
) (
   input logic                  clk,
   input logic                  resetn,
   sram_like_responder_if.slave bus
);
   localparam int TIMER_W = $clog2(DATA_LAT + 4);

   logic [ENTRY_DATA_W-1:0] mem [2**ADDR_W];

   logic [ADDR_W-1:0]       word_idx;
   logic                    accept;
   logic                    addr_ok_q, addr_ok_d;
   logic [TIMER_W-1:0]      push_timer;
   logic [ENTRY_DATA_W-1:0] push_data;
   logic [ENTRY_DATA_W-1:0] head_data;
   logic                    fifo_empty, head_expired, full_next;
   logic                    data_ok;
   logic                    unused_bits;

   assign word_idx  = bus.addr[ADDR_W+1:2];
   assign accept    = bus.req && addr_ok_q;
   assign push_data = bus.wr ? '0 : mem[word_idx];
   assign data_ok   = !fifo_empty && head_expired;

   assign bus.addr_ok = addr_ok_q;
   assign bus.data_ok = data_ok;
   assign bus.rdata   = data_ok ? head_data : '0;

   // Size, byte offset and high address bits do not affect behaviour
   assign unused_bits = ^{bus.size == SRAM_SIZE_B, bus.size == SRAM_SIZE_H,
                          bus.size == SRAM_SIZE_W, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

   // Byte-strobed write into the backing store in the accept cycle
   always_ff @(posedge clk) begin
      if (accept && bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) begin
               mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

`ifdef SRAM_RANDOM_DELAY_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Acceptance is throttled by the next LFSR state; timers get 0-3 extra cycles
   always_comb begin
      lfsr_d     = lfsr_next(lfsr_q);
      addr_ok_d  = !full_next && !lfsr_d[0];
      push_timer = TIMER_W'(DATA_LAT - 1) + TIMER_W'(lfsr_q[2:1]);
   end

   // Free-running LFSR
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   // addr_ok follows next-cycle occupancy, so a retiring entry never bypasses
   always_comb begin
      addr_ok_d  = !full_next;
      push_timer = TIMER_W'(DATA_LAT - 1);
   end
`endif

   // addr_ok is a flop so it carries no path from req
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_ok_q <= 1'b0;
      end else begin
         addr_ok_q <= addr_ok_d;
      end
   end

   sram_resp_fifo #(
      .DEPTH   (MAX_OUTSTANDING),
      .TIMER_W (TIMER_W)
   ) u_fifo (
      .clk          (clk),
      .resetn       (resetn),
      .push         (accept),
      .push_data    (push_data),
      .push_timer   (push_timer),
      .pop          (data_ok),
      .empty        (fifo_empty),
      .head_expired (head_expired),
      .head_data    (head_data),
      .full_next    (full_next)
   );
endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench for sram_like_responder: directed cases then random traffic.
module tb_sram_like_responder;
   localparam int ADDR_W  = 10;
   localparam int MAX_OUT = 2;
   localparam int LAT     = 2;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   sram_like_responder_if bus_if ();

   sram_like_responder #(
      .ADDR_W          (ADDR_W),
      .MAX_OUTSTANDING (MAX_OUT),
      .DATA_LAT        (LAT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   exp_t        sb[$];
   int          dok_log[$];
   bit          ok_log[$];
   bit          log_en = 1'b0;
   logic [31:0] model_mem [int];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every data_ok pops the oldest expected response
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (resetn && bus_if.data_ok) begin
         dok_log.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_data_ok: got data_ok=1 rdata=%h with nothing outstanding, required data_ok=0", bus_if.rdata);
         end else begin
            e = sb.pop_front();
            check("rdata", bus_if.rdata, e.data);
            lat = cyc - e.cyc;
`ifdef SRAM_RANDOM_DELAY_EN
            checks++;
            if (lat < LAT || lat > LAT + 3) begin
               errors++;
               $display("FAIL latency: got %0d required %0d..%0d", lat, LAT, LAT + 3);
            end
`else
            check("latency", 32'(lat), 32'(LAT));
`endif
         end
      end
   end

   // Drive a request (called just after a rising edge) and hold it until accepted
   task automatic issue(input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
      int          waited;
      int          idx;
      logic [31:0] word;
      exp_t        e;
      waited        = 0;
      bus_if.req    = 1'b1;
      bus_if.wr     = w;
      bus_if.wstrb  = s;
      bus_if.addr   = a;
      bus_if.wdata  = d;
      bus_if.size   = sz;
      @(negedge clk);
      if (log_en) ok_log.push_back(bus_if.addr_ok);
      while (!bus_if.addr_ok && waited < 50) begin
         @(negedge clk);
         waited++;
         if (log_en) ok_log.push_back(bus_if.addr_ok);
      end
      check("accept_wait", {31'd0, bus_if.addr_ok}, 32'd1);
      if (bus_if.addr_ok) begin
         idx  = int'((a >> 2) % (32'd1 << ADDR_W));
         word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
         if (w) begin
            for (int i = 0; i < 4; i++) begin
               if (s[i]) word[8*i +: 8] = d[8*i +: 8];
            end
            model_mem[idx] = word;
            e.data = 32'h0;
         end else begin
            e.data = word;
         end
         e.cyc = cyc;
         sb.push_back(e);
         check("outstanding_le_max", {31'd0, sb.size() <= MAX_OUT}, 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus_if.req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus_if.req = 1'b0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          t0;
      int          widx;
      logic [31:0] a;
      int          exp_ok[5];
      int          exp_dok[4];
      exp_ok  = '{1, 1, 0, 1, 1};
      exp_dok = '{2, 3, 5, 6};

      bus_if.req   = 1'b0;
      bus_if.wr    = 1'b0;
      bus_if.size  = 2'd0;
      bus_if.wstrb = 4'd0;
      bus_if.addr  = 32'd0;
      bus_if.wdata = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_addr_ok", {31'd0, bus_if.addr_ok}, 32'd0);
      check("reset_data_ok", {31'd0, bus_if.data_ok}, 32'd0);
      check("reset_rdata", bus_if.rdata, 32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Initialise word window 0..15 (word 4 holds 32'h12345678)
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 4'hF, 32'(i * 4), (i == 4) ? 32'h12345678 : $urandom, 2'd2);
      end
      drain();

      // Single read
      issue(1'b0, 4'h0, 32'h10, 32'h0, 2'd2);
      drain();

      // Byte write then read
      issue(1'b1, 4'b0010, 32'h10, 32'h0000AB00, 2'd0);
      issue(1'b0, 4'h0, 32'h10, 32'h0, 2'd2);
      drain();
      check("model_byte_merge", model_mem[4], 32'h1234AB78);

      // Back-to-back reads with req held high
      dok_log.delete();
      ok_log.delete();
      log_en = 1'b1;
      t0 = cyc;
      issue(1'b0, 4'h0, 32'h10, 32'h0, 2'd2);
      issue(1'b0, 4'h0, 32'h14, 32'h0, 2'd2);
      issue(1'b0, 4'h0, 32'h18, 32'h0, 2'd2);
      issue(1'b0, 4'h0, 32'h1C, 32'h0, 2'd2);
      log_en = 1'b0;
      drain();
`ifndef SRAM_RANDOM_DELAY_EN
      check("b2b_addr_ok_samples", 32'(ok_log.size()), 32'd5);
      for (int i = 0; i < 5 && i < ok_log.size(); i++) begin
         check($sformatf("b2b_addr_ok[T+%0d]", i), {31'd0, ok_log[i]}, 32'(exp_ok[i]));
      end
      check("b2b_data_ok_count", 32'(dok_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < dok_log.size(); i++) begin
         check($sformatf("b2b_data_ok_cycle%0d", i), 32'(dok_log[i] - t0), 32'(exp_dok[i]));
      end
`endif

      // Address wrap-around
      issue(1'b1, 4'hF, 32'h00001004, 32'hDEADBEEF, 2'd2);
      issue(1'b0, 4'h0, 32'h00000004, 32'h0, 2'd2);
      drain();

      // Reset with two reads in flight
      issue(1'b0, 4'h0, 32'h20, 32'h0, 2'd2);
      issue(1'b0, 4'h0, 32'h24, 32'h0, 2'd2);
      bus_if.req = 1'b0;
      resetn     = 1'b0;
      sb.delete();
      @(negedge clk);
      check("midreset_addr_ok", {31'd0, bus_if.addr_ok}, 32'd0);
      check("midreset_data_ok", {31'd0, bus_if.data_ok}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      dok_log.delete();
      @(negedge clk);
`ifndef SRAM_RANDOM_DELAY_EN
      check("post_reset_addr_ok", {31'd0, bus_if.addr_ok}, 32'd1);
`endif
      repeat (9) @(negedge clk);
      check("post_reset_data_ok_count", 32'(dok_log.size()), 32'd0);
      @(posedge clk);
      #1;

      // Random traffic over the initialised window, with aliased high bits
      for (int n = 0; n < 200; n++) begin
         widx = $urandom_range(0, 15);
         a    = ($urandom & 32'hFFFF_F000) | 32'(widx << 2) | 32'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
               2'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Slave end of the SRAM-like bus (req / addr_ok / data_ok) that the IF and MEM stages drive as initiators.
- Holds a word-addressed backing memory, accepts read and write requests, and returns in-order responses after a fixed latency.
- Used in place of the AXI bridge for stage-level simulation, so the initiator's addr_ok/data_ok handling can be exercised with multiple outstanding requests and stalls.

Parameters:
- ADDR_W, 10: word-index bits; memory is 2^ADDR_W x 32 bit.
- MAX_OUTSTANDING, 2: accepted requests not yet answered with data_ok; range 1..4.
- DATA_LAT, 2: minimum cycles from the addr_ok handshake to data_ok; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous reset, active low.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; passed through only, not checked.
- wstrb  in  4  byte enables for writes.
- addr  in  32  byte address.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req is also high.
- data_ok  out  1  one-cycle response pulse, in request order.
- rdata  out  32  read data, valid only while data_ok is high.

Behaviour:
- Reset: while resetn is low, addr_ok=0, data_ok=0 and rdata=0. The response queue is emptied and all counters are cleared. Memory contents are not reset. Reset mid-operation drops every outstanding response; no data_ok appears afterwards for those requests.
- Handshake: a request is accepted in cycle T when req && addr_ok. addr_ok = (count < MAX_OUTSTANDING), with no same-cycle bypass from a retiring entry. addr_ok may be high while req is low.
- Address mapping: word index = addr[ADDR_W+1:2]. Upper bits are ignored and wrap modulo the memory size. addr[1:0] is ignored; wstrb alone selects bytes.
- Write: in the accept cycle, each byte i of mem[index] with wstrb[i]=1 takes wdata[8i+7:8i]. A queue entry is pushed with is_write=1.
- Read: mem[index] is sampled at accept and stored in the queue entry. A read accepted after a write to the same word returns the new data. rdata for write responses is 0.
- Queue: circular FIFO, depth MAX_OUTSTANDING, holding {data[31:0], timer}. timer loads DATA_LAT-1 on push and decrements every cycle while nonzero, for all entries.
- Pop: data_ok=1 in the cycle the head timer is 0 and the queue is non-empty. rdata = head data. The head pops that cycle.
- Latency: a request accepted in cycle T gets data_ok in cycle T+DATA_LAT at the earliest. At most one data_ok per cycle; responses never reorder.
- Simultaneous push and pop: allowed; count stays unchanged and pointers advance independently. Full with a pop in the same cycle: addr_ok stays 0 this cycle and rises next cycle.
- Widths: count is $clog2(MAX_OUTSTANDING+1) bits; pointers wrap modulo MAX_OUTSTANDING (explicit compare, not power-of-two masking).
- Outputs: addr_ok, data_ok and rdata are driven from registered state only; there is no combinational path from req.

Optional Feature:
- Macro: SRAM_RANDOM_DELAY_EN.
- When defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, taps 16,14,13,11), advancing every cycle, gates addr_ok low whenever lfsr[0]=1.
  - A pushed timer loads DATA_LAT-1+lfsr[2:1], giving 0-3 extra cycles.
  - Order is still enforced: a younger entry whose timer reaches 0 waits for the head.
- When not defined: no LFSR, and latency is exactly as stated under Behaviour.

Decomposition:
- In mycpu.h:
  - SRAM size encodings SRAM_SIZE_B/H/W.
  - LFSR seed constant.
  - Width macros for the queue entry.
- Natural sub-module: sram_resp_fifo (circular FIFO with per-entry timers, push/pop/full/empty). The top holds the memory array, the write-strobe merge and addr_ok generation.

Test Plan:
- Single read: preload mem[4]=32'h12345678; req, rd, addr=32'h10 at T -> addr_ok=1 at T, data_ok=1 with rdata=32'h12345678 at T+2, data_ok=0 elsewhere.
- Byte write then read: write addr=32'h10, wstrb=4'b0010, wdata=32'h0000AB00, then read 32'h10 -> write data_ok with rdata=0, then read returns 32'h1234AB78.
- Back-to-back: req held high for 4 reads, MAX_OUTSTANDING=2, DATA_LAT=2 -> addr_ok pattern 1,1,0,1,1 (T..T+4) and data_ok at T+2, T+3, T+5, T+6, in address order. The stall at T+2 confirms there is no bypass.
- Wrap-around: ADDR_W=10, write 32'h00001004 with data 32'hDEADBEEF, then read 32'h00000004 -> 32'hDEADBEEF.
- Reset mid-flight: two reads accepted, then resetn=0 for one cycle before either data_ok -> no data_ok for 10 cycles after release; addr_ok=1 the first cycle after release.
- SRAM_RANDOM_DELAY_EN defined: 200 random requests against a scoreboard -> every response in order, each latency within DATA_LAT..DATA_LAT+3, outstanding never more than MAX_OUTSTANDING.
